// File: rtl/wave_capture.sv
// Zero-crossing triggered waveform capture into a double-buffered display RAM.
// Arms on a positive zero crossing, writes one full buffer half, then swaps once the reader is idle.
module wave_capture #(
  parameter int SAMPLE_W    = 16,
  parameter int NUM_SAMPLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);

  state_t              state;
  logic [7:0]          count;
  logic [SAMPLE_W-1:0] prev_sample;
  logic                zero_cross;
  logic                unused_prev;

  // Only the sign of the previous sample matters for triggering.
  assign unused_prev = ^prev_sample[SAMPLE_W-2:0];
  assign zero_cross  = new_sample_ready && prev_sample[SAMPLE_W-1] && !new_sample_in[SAMPLE_W-1];

  assign write_enable  = !reset && (state == ACTIVE) && new_sample_ready;
  assign write_address = {~read_index, count};
  // Offset binary: flipping the sign bit maps signed range onto 0x00..0xFF.
  assign write_sample  = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARMED;
      count       <= '0;
      prev_sample <= '0;
      read_index  <= 1'b0;
    end else begin
      if (new_sample_ready) prev_sample <= new_sample_in;
      case (state)
        ARMED: begin
          if (zero_cross) begin
            state <= ACTIVE;
            count <= '0;
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            count <= count + 8'd1;
            if (count == LAST_IDX) state <= WAIT;
          end
        end
        WAIT: begin
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, width of the signed two's-complement input sample.
REQ-002 SHALL have parameter NUM_SAMPLES, default 256, samples per capture; fixed at 256 because the address map is 8 bits per half.
REQ-003 SHALL have the following ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  SAMPLE_W  signed audio sample.
- wave_display_idle  input  1  high while the display reader is outside its active region; buffer swap is permitted.
- write_address  output  9  RAM write address {buffer, index[7:0]}.
- write_enable  output  1  RAM write strobe.
- write_sample  output  8  unsigned offset-binary sample written to the RAM.
- read_index  output  1  selects the buffer half the display reads; the capture block writes the other half.

Function
REQ-004 SHALL implement a three-state FSM: ARMED, ACTIVE, WAIT.
REQ-005 SHALL hold a SAMPLE_W-bit prev_sample register, loaded with new_sample_in on every cycle with new_sample_ready=1, in every state.
REQ-006 SHALL detect a positive zero crossing when new_sample_ready=1, prev_sample[MSB]=1 and new_sample_in[MSB]=0.
REQ-007 ARMED: on a positive zero crossing SHALL go to ACTIVE with count=0; otherwise SHALL stay in ARMED; no writes occur in ARMED, including on the triggering sample.
REQ-008 ACTIVE: on each new_sample_ready SHALL assert write_enable in the same cycle (combinational) and increment count on the clock edge.
REQ-009 ACTIVE: cycles without new_sample_ready SHALL hold write_enable=0 and leave count unchanged.
REQ-010 write_address SHALL equal {~read_index, count[7:0]} in all states; only write_enable qualifies it.
REQ-011 write_sample SHALL equal {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]}, i.e. the top 8 bits with the MSB inverted (-32768 -> 0x00, 0 -> 0x80, 32767 -> 0xFF).
REQ-012 On the write with count=255 SHALL go to WAIT and wrap count to 0; exactly 256 writes occur per capture, at indices 0..255 in order.
REQ-013 WAIT: SHALL ignore new_sample_ready for writing (write_enable=0), while prev_sample still updates per REQ-005.
REQ-014 WAIT: on the first cycle with wave_display_idle=1 SHALL toggle read_index and go to ARMED; otherwise SHALL stay in WAIT.
REQ-015 read_index SHALL change only on the WAIT-to-ARMED transition; wave_display_idle SHALL be ignored in ARMED and ACTIVE.
REQ-016 A zero crossing in the same cycle as the WAIT-to-ARMED transition SHALL NOT trigger; triggering is evaluated in ARMED only.
REQ-017 count SHALL be 8 bits; no other arithmetic is performed.

Reset
REQ-018 While reset=1 at a clock edge SHALL set state=ARMED, count=0, prev_sample=0 and read_index=0.
REQ-019 While reset=1 SHALL hold write_enable=0, regardless of new_sample_ready.
REQ-020 Reset asserted in ACTIVE or WAIT SHALL abandon the partial capture, without a buffer swap, and return to ARMED.
REQ-021 After reset, the first trigger SHALL require a negative sample followed by a non-negative one, because prev_sample=0 is non-negative.

Verification
REQ-022 Reset, then samples 100, 200 -> no write_enable, state remains ARMED.
REQ-023 Samples -5 then 3, then 256 samples of value 0x1234 -> 256 writes at addresses 0x100..0x1FF with write_sample=0x92, then WAIT, read_index=0.
REQ-024 In WAIT with wave_display_idle=0 for 50 cycles and samples applied -> no writes, read_index=0; raise wave_display_idle -> read_index=1 next cycle, state ARMED.
REQ-025 Second capture after the swap -> writes go to addresses 0x000..0x0FF; write_sample for inputs -32768, 0, 32767 is 0x00, 0x80, 0xFF.
REQ-026 new_sample_ready pulsed every 4th cycle in ACTIVE -> write_enable only on strobe cycles, count unchanged between strobes.
REQ-027 Reset asserted after 100 writes -> write_enable=0, read_index=0, ARMED; a new crossing restarts the capture at index 0.
